// File: rtl/nonce_gen_multi_pkg.sv
// rtl/nonce_gen_multi_pkg.sv - shared types, sizes and helpers for the multi-lane nonce generator
//
// Contents:
//   state_t          - generator FSM states
//   HDR_WORDS        - 32-bit words per block header
//   HDR_W            - block header width in bits
//   FRAME_WORDS      - 64-bit header words per hashin frame (PAD word excluded)
//   PAD_WORD_DEFAULT - first 64-bit word of every hashin frame
//   bswap32          - 32-bit byte swap
package nonce_gen_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_READ_HDR  = 3'd1,
        ST_CALC      = 3'd2,
        ST_DISPATCH  = 3'd3,
        ST_WRITE_HDR = 3'd4
    } state_t;

    localparam int HDR_WORDS   = 20;
    localparam int HDR_W       = 640;
    localparam int FRAME_WORDS = 10;

    localparam logic [63:0] PAD_WORD_DEFAULT = 64'h8000_0000_0000_0280;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/nonce_gen_multi_if.sv
// rtl/nonce_gen_multi_if.sv - per-lane hashin / nonce FIFO write bundle
//
// Signals (NUM_LANES lanes, lane i at the i-th slice of each vector):
//   hashin_fifo_in_we   - hashin write enables          (generator -> FIFOs)
//   hashin_fifo_in_din  - hashin data, 64 bits per lane  (generator -> FIFOs)
//   hashin_fifo_in_full - hashin full flags              (FIFOs -> generator)
//   nonce_fifo_we       - nonce write enables            (generator -> FIFOs)
//   nonce_fifo_din      - nonce data, 32 bits per lane   (generator -> FIFOs)
//   nonce_fifo_full     - nonce full flags               (FIFOs -> generator)
// Modports: master (generator side), slave (FIFO side).
interface nonce_gen_multi_if #(
    parameter int NUM_LANES = 4
);
    logic [NUM_LANES-1:0]    hashin_fifo_in_we;
    logic [64*NUM_LANES-1:0] hashin_fifo_in_din;
    logic [NUM_LANES-1:0]    hashin_fifo_in_full;
    logic [NUM_LANES-1:0]    nonce_fifo_we;
    logic [32*NUM_LANES-1:0] nonce_fifo_din;
    logic [NUM_LANES-1:0]    nonce_fifo_full;

    modport master (
        output hashin_fifo_in_we,
        output hashin_fifo_in_din,
        input  hashin_fifo_in_full,
        output nonce_fifo_we,
        output nonce_fifo_din,
        input  nonce_fifo_full
    );

    modport slave (
        input  hashin_fifo_in_we,
        input  hashin_fifo_in_din,
        output hashin_fifo_in_full,
        input  nonce_fifo_we,
        input  nonce_fifo_din,
        output nonce_fifo_full
    );
endinterface

// File: rtl/nonce_range_calc.sv
// rtl/nonce_range_calc.sv - combinational nonce slice bounds for one generator instance
//
// Ports:
//   base        in  32  first header word (slice origin)
//   nonce_size  in  32  slice size
//   range_start out 32  first nonce of this slice (low 32 bits)
//   range_end   out 32  exclusive end, saturated to 32'hFFFFFFFF
//   range_empty out 1   slice starts beyond the 32-bit nonce space
module nonce_range_calc #(
    parameter int NONCE_COEF = 1
) (
    input  logic [31:0] base,
    input  logic [31:0] nonce_size,
    output logic [31:0] range_start,
    output logic [31:0] range_end,
    output logic        range_empty
);

    logic [63:0] s_full;
    logic [63:0] e_full;

    // Full 64-bit arithmetic so that slices past the top of the nonce space
    // are detected rather than wrapped.
    always_comb begin
        s_full = {32'b0, base} + {32'b0, nonce_size} * 64'(NONCE_COEF - 1);
        e_full = {32'b0, base} + {32'b0, nonce_size} * 64'(NONCE_COEF);
    end

    assign range_start = s_full[31:0];
    // Saturating the end at all-ones keeps nonce 0xFFFFFFFF out of every slice.
    assign range_end   = (|e_full[63:32]) ? 32'hFFFF_FFFF : e_full[31:0];
    assign range_empty = |s_full[63:32];

endmodule

// File: rtl/nonce_gen_multi.sv
// rtl/nonce_gen_multi.sv - multi-lane nonce generator feeding NUM_LANES hash cores in lockstep
//
// Optional feature macro: NONCE_GEN_MULTI_DBG_EN (adds state_dbg / stall_cnt_dbg).
//
// Ports:
//   clk             in   1   clock
//   rst_n           in   1   asynchronous active-low reset
//   start           in   1   new header available (sampled in INIT only)
//   stop            in   1   abort request
//   block_header    in   32  header word
//   block_header_we in   1   header word valid
//   nonce_size      in   32  slice size
//   fifo            master  per-lane hashin / nonce FIFO write bundle
//   stop_ack_nonce  out  1   high while idle in INIT
//   nonce_end       out  32  exclusive end of the slice
//   nonces_issued   out  32  nonces dispatched since the last start
//   state_dbg       out  3   FSM state            (NONCE_GEN_MULTI_DBG_EN only)
//   stall_cnt_dbg   out  32  stalled-cycle count  (NONCE_GEN_MULTI_DBG_EN only)
module nonce_gen_multi
    import nonce_gen_pkg::*;
#(
    parameter int          NUM_LANES  = 4,
    parameter int          NONCE_COEF = 1,
    parameter logic [63:0] PAD_WORD   = PAD_WORD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       block_header,
    input  logic              block_header_we,
    input  logic [31:0]       nonce_size,
    nonce_gen_multi_if.master fifo,
    output logic              stop_ack_nonce,
    output logic [31:0]       nonce_end,
    output logic [31:0]       nonces_issued
`ifdef NONCE_GEN_MULTI_DBG_EN
    ,
    output logic [2:0]        state_dbg,
    output logic [31:0]       stall_cnt_dbg
`endif
);

    state_t               state;
    logic [HDR_W-1:0]     hdr;
    logic [4:0]           word_idx;
    logic [3:0]           cnt;
    // One extra bit so stepping past the top of the nonce space cannot wrap
    // back into already-issued nonces.
    logic [32:0]          nonce_cur;
    logic [NUM_LANES-1:0] mask;
    logic                 stop_pend;

    logic [31:0]          range_start;
    logic [31:0]          range_end;
    logic                 range_empty;

    logic [32:0]          lane_nonce [NUM_LANES];
    logic [NUM_LANES-1:0] active;
    logic [NUM_LANES-1:0] lane_full;
    logic                 dispatch_go;
    logic                 frame_go;
    logic                 last_word;
    logic [3:0]           word_sel;
    logic [63:0]          hdr_word;

    function automatic logic [31:0] popcount(input logic [NUM_LANES-1:0] m);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            c = c + {31'b0, m[i]};
        end
        return c;
    endfunction

    nonce_range_calc #(
        .NONCE_COEF (NONCE_COEF)
    ) u_range (
        .base        (hdr[31:0]),
        .nonce_size  (nonce_size),
        .range_start (range_start),
        .range_end   (range_end),
        .range_empty (range_empty)
    );

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_nonce[i] = nonce_cur + 33'(i);
            active[i]     = lane_nonce[i] < {1'b0, nonce_end};
            lane_full[i]  = fifo.hashin_fifo_in_full[i] | fifo.nonce_fifo_full[i];
        end
    end

    // A group is only dispatched when every active lane can take both its
    // PAD word and its nonce, so lanes never drift apart.
    assign dispatch_go = (state == ST_DISPATCH) && !stop && (|active) &&
                         !(|(active & lane_full));
    assign frame_go    = (state == ST_WRITE_HDR) &&
                         !(|(mask & fifo.hashin_fifo_in_full));
    assign last_word   = (cnt == 4'(FRAME_WORDS - 1));

    // Frame word cnt is header bits [639-64cnt : 576-64cnt].
    assign word_sel    = 4'(FRAME_WORDS - 1) - cnt;
    assign hdr_word    = hdr[{word_sel, 6'b0} +: 64];

    always_comb begin
        fifo.hashin_fifo_in_we  = '0;
        fifo.hashin_fifo_in_din = '0;
        fifo.nonce_fifo_we      = '0;
        fifo.nonce_fifo_din     = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (dispatch_go && active[i]) begin
                fifo.hashin_fifo_in_we[i]         = 1'b1;
                fifo.hashin_fifo_in_din[64*i +: 64] = PAD_WORD;
                fifo.nonce_fifo_we[i]             = 1'b1;
                fifo.nonce_fifo_din[32*i +: 32]   = lane_nonce[i][31:0];
            end else if (frame_go && mask[i]) begin
                fifo.hashin_fifo_in_we[i] = 1'b1;
                // The last word carries the header's first 32-bit word slot,
                // replaced by this lane's byte-swapped nonce.
                fifo.hashin_fifo_in_din[64*i +: 64] = last_word ?
                    {hdr[63:32], bswap32(lane_nonce[i][31:0])} : hdr_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_INIT;
            hdr            <= '0;
            word_idx       <= '0;
            cnt            <= '0;
            nonce_cur      <= '0;
            nonce_end      <= '0;
            nonces_issued  <= '0;
            mask           <= '0;
            stop_pend      <= 1'b0;
            stop_ack_nonce <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    stop_ack_nonce <= 1'b1;
                    hdr            <= '0;
                    word_idx       <= '0;
                    cnt            <= '0;
                    nonce_cur      <= '0;
                    nonce_end      <= '0;
                    mask           <= '0;
                    stop_pend      <= 1'b0;
                    if (start) begin
                        nonces_issued <= '0;
                        state         <= ST_READ_HDR;
                    end
                end

                ST_READ_HDR: begin
                    stop_ack_nonce <= 1'b0;
                    if (stop) begin
                        state <= ST_INIT;
                    end else if (block_header_we) begin
                        hdr[{word_idx, 5'b0} +: 32] <= block_header;
                        if (word_idx == 5'(HDR_WORDS - 1)) begin
                            state <= ST_CALC;
                        end else begin
                            word_idx <= word_idx + 5'd1;
                        end
                    end
                end

                ST_CALC: begin
                    stop_ack_nonce <= 1'b0;
                    if (stop) begin
                        state <= ST_INIT;
                    end else begin
                        nonce_cur <= {1'b0, range_start};
                        nonce_end <= range_end;
                        state     <= range_empty ? ST_INIT : ST_DISPATCH;
                    end
                end

                ST_DISPATCH: begin
                    if (stop || (active == '0)) begin
                        state <= ST_INIT;
                    end else if (dispatch_go) begin
                        mask  <= active;
                        cnt   <= '0;
                        state <= ST_WRITE_HDR;
                    end
                end

                ST_WRITE_HDR: begin
                    // A stop here waits for the frame to finish so no lane is
                    // left holding a partial frame.
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (frame_go) begin
                        if (last_word) begin
                            nonce_cur     <= nonce_cur + 33'(NUM_LANES);
                            nonces_issued <= nonces_issued + popcount(mask);
                            stop_pend     <= 1'b0;
                            state         <= (stop_pend || stop) ? ST_INIT : ST_DISPATCH;
                        end else begin
                            cnt <= cnt + 4'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

`ifdef NONCE_GEN_MULTI_DBG_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state == ST_INIT) && start) begin
            stall_cnt <= '0;
        end else if (((state == ST_DISPATCH) && !stop && (|active) && !dispatch_go) ||
                     ((state == ST_WRITE_HDR) && !frame_go)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign state_dbg     = state;
    assign stall_cnt_dbg = stall_cnt;
`endif

endmodule

// File: doc/nonce_gen_multi.md
Name: nonce_gen_multi

Overview:
Parametrised successor of the single-lane nonce generator. It loads one 80-byte block header as twenty 32-bit words and derives this instance's nonce slice from nonce_size and NONCE_COEF. It then feeds NUM_LANES hash cores in lockstep: each dispatch group writes NUM_LANES consecutive nonces, one per lane, into per-lane hashin and nonce FIFOs. It sits between the block-header FIFO and the hash-core array and replaces the one-lane generator when the core count is greater than 1.

Parameters:
NUM_LANES, 4, number of hash lanes fed in parallel (1..16)
NONCE_COEF, 1, 1-based index of this instance's nonce slice
PAD_WORD, 64'h8000000000000280, first 64-bit word of every hashin frame

Ports:
clk  in  1  global clock
rst_n  in  1  asynchronous active-low reset
start  in  1  new header available; sampled in INIT only
stop  in  1  abort request
block_header  in  32  header word from block-header FIFO
block_header_we  in  1  block_header valid
nonce_size  in  32  slice size, computed by software
hashin_fifo_in_we  out  NUM_LANES  per-lane hashin write enable
hashin_fifo_in_din  out  64*NUM_LANES  per-lane hashin data; lane i at bits [64i+63:64i]
hashin_fifo_in_full  in  NUM_LANES  per-lane hashin full
nonce_fifo_we  out  NUM_LANES  per-lane nonce write enable
nonce_fifo_din  out  32*NUM_LANES  per-lane nonce; lane i at bits [32i+31:32i]
nonce_fifo_full  in  NUM_LANES  per-lane nonce full
stop_ack_nonce  out  1  registered; high while idle in INIT
nonce_end  out  32  registered exclusive end of the slice
nonces_issued  out  32  nonces dispatched since the last start

Behaviour:
- Reset (async assert, sync release): state INIT. All registers are 0. All we outputs and din outputs are 0. stop_ack_nonce is 0 and rises 1 cycle after reset release.
- The FIFO outputs (we, din) are combinational from state. They are 0 whenever they are not being written.
- States: INIT, READ_HDR, CALC, DISPATCH, WRITE_HDR.
- INIT:
  - stop_ack_next=1; header, counters and nonce registers are cleared.
  - On start, go to READ_HDR and clear nonces_issued.
- READ_HDR:
  - stop_ack_next=0.
  - Each block_header_we stores word k at hdr[32k+31:32k], k=0..19.
  - On accepting word 19, go to CALC. block_header_we is ignored outside READ_HDR.
- CALC (1 cycle), using 64-bit arithmetic with base=hdr[31:0]:
  - s = base + nonce_size*(NONCE_COEF-1)
  - e = base + nonce_size*NONCE_COEF
  - nonce_cur = s[31:0]
  - nonce_end = (e > 2^32-1) ? 32'hFFFFFFFF : e[31:0]
  - If s > 2^32-1, the range is empty: go to INIT. Otherwise go to DISPATCH.
- Lane i in the current group is active iff nonce_cur+i (33-bit) < nonce_end. nonce 0xFFFFFFFF is never issued.
- DISPATCH:
  - If stop is high, go to INIT.
  - Else if no lane is active, go to INIT.
  - Else, when every active lane has both full flags low, write in the same cycle for each active lane:
    - hashin_fifo_in_we[i]=1 with din=PAD_WORD
    - nonce_fifo_we[i]=1 with din=nonce_cur+i
  - Latch the active mask, clear cnt, go to WRITE_HDR.
  - Inactive lanes are never written. If any active lane is full, stall with no writes.
- WRITE_HDR, for cnt=0..9:
  - Each lane's frame is hdr with bits [31:0] replaced by the byte-swapped nonce ({n[7:0],n[15:8],n[23:16],n[31:24]}).
  - Word cnt is bits [639-64cnt : 576-64cnt].
  - It is written to all latched lanes in one cycle, only when every latched hashin full flag is low. Otherwise stall.
  - After word 9: nonce_cur += NUM_LANES, nonces_issued += popcount(mask), go to DISPATCH.
- Frame: 11 words per lane, PAD first. Best case is 11 cycles per group.
- Latency: the 20th header word at cycle T gives CALC at T+1 and the first PAD write at T+2.
- stop during WRITE_HDR is latched (stop_pend). The frame completes, then the block goes to INIT; partial frames are never left in the FIFOs. stop in READ_HDR or CALC goes to INIT immediately.
- start outside INIT is ignored.
- Reset mid-frame discards everything. Downstream FIFOs are reset by the same rst_n.

Optional Feature:
NONCE_GEN_MULTI_DBG_EN:
- When defined, adds the output ports state_dbg[2:0] (state encoding) and stall_cnt_dbg[31:0]. stall_cnt_dbg counts cycles spent stalled in DISPATCH or WRITE_HDR and clears on start.
- When undefined, these ports and their logic are absent; functional behaviour is identical.

Decomposition:
- Package nonce_gen_pkg holds:
  - the state enum typedef
  - HDR_WORDS=20, HDR_W=640, FRAME_WORDS=10
  - the PAD_WORD default
  - a function bswap32
- One sub-module, nonce_range_calc: combinational s/e/saturation/empty computation. It is registered in CALC by the parent.

Test Plan:
1. NUM_LANES=4, COEF=1, base=0x100, size=8 -> nonce_end=0x108. Two groups; lane i gets 0x100+i and 0x104+i. Each lane receives 11 words, PAD first. nonces_issued=8, then INIT.
2. base=0x100, size=6, 4 lanes -> second group activates lanes 0-1 only (0x104, 0x105). Lanes 2-3 we stay 0. nonces_issued=6.
3. COEF=2, base=0xFFFFFFF0, size=0x10 -> s=0x1_0000_0000, empty range. No FIFO writes; back to INIT with nonces_issued=0.
4. COEF=1, base=0xFFFFFFFC, size=0x10 -> nonce_end=0xFFFFFFFF. Only 0xFFFFFFFC..0xFFFFFFFE are issued (3 lanes active).
5. Hold hashin_fifo_in_full[2]=1 for 5 cycles mid-WRITE_HDR -> no lane writes during the stall. All lanes resume on the same word; frame contents unchanged.
6. Assert stop at WRITE_HDR cnt=3 -> words 3..9 are still written, then INIT. stop_ack_nonce=1 one cycle later; no further PAD words.
